// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only); backpressure: n/a.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam int          NUM_DIGITS = 4;
  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;

  function automatic logic [3:0] digit_nibble(input logic [15:0] v, input logic [1:0] k);
    return v[{k, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/one_cold.sv
// Decodes a digit index into active-low one-cold anode enables.
// Latency: combinational; backpressure: none.
module one_cold
  import seg_pkg::*;
(
  input  logic [1:0]            sel,
  output logic [NUM_DIGITS-1:0] an_n
);

  assign an_n = ~(4'b0001 << sel);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller; SEG_SCAN_CTRL_BLANK_EN inserts an all-off gap after each slot.
// Latency: all outputs registered, SHOW(0) begins one cycle after en sampled high; backpressure: none.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digit_val,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [1:0]  sel,
  output logic [3:0]  an_n,
  output logic [3:0]  hex,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
`ifdef SEG_SCAN_CTRL_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
`endif

  scan_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    sel_d;
  logic [3:0]    hex_d;
  logic          dp_d;
  logic          tick_d;
  logic [3:0]    dec_n;
  logic [3:0]    an_d;
  logic          an_off;

  // Decoder sees the next digit index so an_n lands on the same edge as sel.
  one_cold u_dec (
    .sel  (sel_d),
    .an_n (dec_n)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    sel_d   = sel;
    hex_d   = hex;
    dp_d    = dp;
    tick_d  = 1'b0;
    case (state)
      IDLE: begin
        state_d = SHOW;
        cnt_d   = '0;
        sel_d   = 2'd0;
        hex_d   = digit_nibble(digit_val, 2'd0);
        dp_d    = dp_in[0];
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_d  = '0;
          sel_d  = sel + 2'd1;
          tick_d = (sel == 2'd3);
`ifdef SEG_SCAN_CTRL_BLANK_EN
          state_d = BLANK;
`else
          hex_d = digit_nibble(digit_val, sel_d);
          dp_d  = dp_in[sel_d];
`endif
        end
      end
`ifdef SEG_SCAN_CTRL_BLANK_EN
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          hex_d   = digit_nibble(digit_val, sel);
          dp_d    = dp_in[sel];
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Dropping en wins over everything, including a pending wrap tick.
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 2'd0;
      tick_d  = 1'b0;
    end
    an_off = (state_d != SHOW) || !digit_en[sel_d];
    an_d   = dec_n | {NUM_DIGITS{an_off}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 2'd0;
      an_n       <= AN_ALL_OFF;
      hex        <= 4'h0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sel        <= sel_d;
      an_n       <= an_d;
      hex        <= hex_d;
      dp         <= dp_d;
      frame_tick <= tick_d;
    end
  end

endmodule
